// File: rtl/redbus_host_bridge.sv
// ---------------------------------------------------------------------------
// redbus_host_bridge
//
// Upstream stage of every redbus peripheral. A CPU load or store that falls in
// the 256-byte redbus window becomes one redbus transaction: a registered
// read or write strobe, a zero-extended window offset, store data and a
// latched device id. The CPU is stalled until the device acks or the strobe
// has been up for TIMEOUT cycles. An abandoned transfer returns 8'hFF on
// loads and sets the sticky RbTimeout flag.
//
// Ports
//   Clock        in   1   single clock, all state changes on posedge
//   Reset        in   1   asynchronous, active-high
//   CpuAddress   in   16  CPU address
//   CpuWData     in   8   CPU store data
//   CpuRead      in   1   CPU load request (level, held until CpuWait low)
//   CpuWrite     in   1   CPU store request (level, held until CpuWait low)
//   CpuRData     out  8   load result, valid once CpuWait falls
//   CpuWait      out  1   stall to CPU
//   RbEnable     in   1   redbus window mapped
//   RbDevice     in   8   target device id
//   RbDeviceSel  out  8   device id latched for the current transfer
//   Address      out  16  window offset {8'h00, CpuAddress[7:0]}
//   DataOut      out  8   store data to device
//   DataIn       in   8   load data from device
//   ReadRedbus   out  1   read strobe
//   WriteRedbus  out  1   write strobe
//   RbAck        in   1   device ack, sampled on posedge
//   RbTimeout    out  1   sticky: last transfer timed out
// ---------------------------------------------------------------------------
module redbus_host_bridge #(
    parameter logic [15:0] WINDOW_BASE = 16'h0300,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] CpuAddress,
    input  logic [7:0]  CpuWData,
    input  logic        CpuRead,
    input  logic        CpuWrite,
    output logic [7:0]  CpuRData,
    output logic        CpuWait,
    input  logic        RbEnable,
    input  logic [7:0]  RbDevice,
    output logic [7:0]  RbDeviceSel,
    output logic [15:0] Address,
    output logic [7:0]  DataOut,
    input  logic [7:0]  DataIn,
    output logic        ReadRedbus,
    output logic        WriteRedbus,
    input  logic        RbAck,
    output logic        RbTimeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter value seen in the last strobe cycle before giving up.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;

    logic [7:0] offset_q;
    logic [7:0] wdata_q;
    logic [7:0] device_q;
    logic       is_write_q;
    logic [7:0] count_q;
    logic [7:0] rdata_q;
    logic       timeout_q;
    logic       read_q;
    logic       write_q;

    logic       hit;
    logic       expired;
    logic       stall;

    assign hit = RbEnable
               && (CpuAddress[15:8] == WINDOW_BASE[15:8])
               && (CpuRead || CpuWrite);

    assign expired = (count_q == LAST_COUNT);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and stall
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the request cycle itself so the CPU never sees a
                // completed access before the transfer has started.
                stall = hit;
                if (hit) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                stall      = 1'b1;
                state_next = STROBE;
            end
            STROBE: begin
                stall = 1'b1;
                if (RbAck || expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Wait for the CPU to drop its request; otherwise a held
                // level request would be replayed as a second transfer.
                if (!CpuRead && !CpuWrite) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset forces the stall low immediately even while a request is held.
    assign CpuWait = stall && !Reset;

    // -----------------------------------------------------------------------
    // Transfer latches, timeout counter, read data and strobes
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            offset_q   <= 8'h00;
            wdata_q    <= 8'h00;
            device_q   <= 8'h00;
            is_write_q <= 1'b0;
            count_q    <= 8'h00;
            rdata_q    <= 8'h00;
            timeout_q  <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            // Strobes are flops driven from the next state, so they are high
            // exactly during STROBE and cannot glitch. Direction is stable by
            // the time STROBE can be entered (it is latched leaving IDLE).
            read_q  <= (state_next == STROBE) && !is_write_q;
            write_q <= (state_next == STROBE) &&  is_write_q;

            case (state)
                IDLE: begin
                    if (hit) begin
                        // Everything the transfer needs is captured here, so
                        // later changes of RbEnable/RbDevice are ignored.
                        offset_q   <= CpuAddress[7:0];
                        wdata_q    <= CpuWData;
                        device_q   <= RbDevice;
                        is_write_q <= CpuWrite;   // read+write counts as write
                    end
                end
                SETUP: begin
                    count_q   <= 8'h00;
                    timeout_q <= 1'b0;
                end
                STROBE: begin
                    count_q <= count_q + 8'd1;
                    // An ack in the final strobe cycle beats the timeout.
                    if (RbAck) begin
                        if (!is_write_q) begin
                            rdata_q <= DataIn;
                        end
                    end else if (expired) begin
                        timeout_q <= 1'b1;
                        if (!is_write_q) begin
                            rdata_q <= 8'hFF;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Address     = {8'h00, offset_q};
    assign DataOut     = wdata_q;
    assign RbDeviceSel = device_q;
    assign CpuRData    = rdata_q;
    assign RbTimeout   = timeout_q;
    assign ReadRedbus  = read_q;
    assign WriteRedbus = write_q;

endmodule

// File: tb/tb_redbus_host_bridge.sv
// ---------------------------------------------------------------------------
// tb_redbus_host_bridge
//
// Self-checking bench for redbus_host_bridge. A bench-side device responds to
// the strobes with an ack on a chosen strobe cycle (or never). Expected
// results come from a transaction-level model: whether the access hits the
// window, how many strobe cycles it should take, what CpuRData and RbTimeout
// must read afterwards.
// ---------------------------------------------------------------------------
module tb_redbus_host_bridge;

    localparam int TMO = 15;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] CpuAddress;
    logic [7:0]  CpuWData;
    logic        CpuRead;
    logic        CpuWrite;
    logic [7:0]  CpuRData;
    logic        CpuWait;
    logic        RbEnable;
    logic [7:0]  RbDevice;
    logic [7:0]  RbDeviceSel;
    logic [15:0] Address;
    logic [7:0]  DataOut;
    logic [7:0]  DataIn;
    logic        ReadRedbus;
    logic        WriteRedbus;
    logic        RbAck;
    logic        RbTimeout;

    int checks = 0;
    int errors = 0;

    // Model state carried between transfers.
    logic [7:0] exp_rdata;
    logic       exp_to;

    redbus_host_bridge dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .CpuAddress  (CpuAddress),
        .CpuWData    (CpuWData),
        .CpuRead     (CpuRead),
        .CpuWrite    (CpuWrite),
        .CpuRData    (CpuRData),
        .CpuWait     (CpuWait),
        .RbEnable    (RbEnable),
        .RbDevice    (RbDevice),
        .RbDeviceSel (RbDeviceSel),
        .Address     (Address),
        .DataOut     (DataOut),
        .DataIn      (DataIn),
        .ReadRedbus  (ReadRedbus),
        .WriteRedbus (WriteRedbus),
        .RbAck       (RbAck),
        .RbTimeout   (RbTimeout)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One CPU access. ack_at = strobe cycle (1-based) on which the device
    // acks; values outside 1..TMO mean the device never acks in time.
    // hold = extra cycles the CPU keeps its request up after the stall ends.
    task automatic xfer(input string tag, input logic [15:0] addr,
                        input logic [7:0] wd, input logic rd, input logic wr,
                        input logic en, input logic [7:0] dev,
                        input int ack_at, input logic [7:0] din, input int hold);
        logic exp_hit;
        logic exp_timed;
        int   exp_strobes;
        int   n_rd, n_wr, n_wait, k, extra, bad_hold;
        bit   done;

        exp_hit     = en && (addr[15:8] == 8'h03) && (rd || wr);
        exp_timed   = !(ack_at >= 1 && ack_at <= TMO);
        exp_strobes = exp_timed ? TMO : ack_at;

        @(posedge Clock); #1;
        CpuAddress = addr; CpuWData = wd; CpuRead = rd; CpuWrite = wr;
        RbEnable = en; RbDevice = dev; DataIn = din; RbAck = 1'b0;

        @(negedge Clock);
        checks++;
        if (CpuWait !== exp_hit) begin
            errors++;
            $display("FAIL %s request_wait got %b want %b", tag, CpuWait, exp_hit);
        end

        n_rd = 0; n_wr = 0; n_wait = 0; k = 0; extra = 0; bad_hold = 0; done = 0;

        if (exp_hit) begin
            // Disturb the MMU inputs once the request is latched.
            @(posedge Clock); #1;
            RbEnable = 1'($urandom_range(0, 1));
            RbDevice = 8'($urandom);

            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge Clock);
                if (ReadRedbus)  n_rd++;
                if (WriteRedbus) n_wr++;
                if (CpuWait) begin
                    n_wait++;
                    if (Address !== {8'h00, addr[7:0]} || DataOut !== wd ||
                        RbDeviceSel !== dev)
                        bad_hold++;
                    if (ReadRedbus || WriteRedbus) k++;
                    RbAck = (ReadRedbus || WriteRedbus) && (k == ack_at);
                end else begin
                    done  = 1;
                    RbAck = 1'b0;
                end
            end

            if (!wr) exp_rdata = exp_timed ? 8'hFF : din;
            exp_to = exp_timed;

            checks++;
            if (!done) begin
                errors++;
                $display("FAIL %s completion got stalled want done within 40 cycles", tag);
            end
            checks++;
            if (n_rd !== (wr ? 0 : exp_strobes)) begin
                errors++;
                $display("FAIL %s read_strobes got %0d want %0d", tag, n_rd, wr ? 0 : exp_strobes);
            end
            checks++;
            if (n_wr !== (wr ? exp_strobes : 0)) begin
                errors++;
                $display("FAIL %s write_strobes got %0d want %0d", tag, n_wr, wr ? exp_strobes : 0);
            end
            checks++;
            if (n_wait !== exp_strobes + 1) begin
                errors++;
                $display("FAIL %s wait_cycles got %0d want %0d", tag, n_wait, exp_strobes + 1);
            end
            checks++;
            if (bad_hold !== 0 || Address !== {8'h00, addr[7:0]} || DataOut !== wd ||
                RbDeviceSel !== dev) begin
                errors++;
                $display("FAIL %s bus_hold got addr %h data %h dev %h (%0d bad cycles) want %h %h %h",
                         tag, Address, DataOut, RbDeviceSel, bad_hold,
                         {8'h00, addr[7:0]}, wd, dev);
            end
        end else begin
            for (int c = 0; c < 3; c++) begin
                @(negedge Clock);
                if (ReadRedbus || WriteRedbus || CpuWait) extra++;
            end
            checks++;
            if (extra !== 0) begin
                errors++;
                $display("FAIL %s miss_quiet got %0d active cycles want 0", tag, extra);
            end
        end

        checks++;
        if (CpuRData !== exp_rdata) begin
            errors++;
            $display("FAIL %s rdata got %h want %h", tag, CpuRData, exp_rdata);
        end
        checks++;
        if (RbTimeout !== exp_to) begin
            errors++;
            $display("FAIL %s timeout_flag got %b want %b", tag, RbTimeout, exp_to);
        end

        // CPU keeps (or drops) its request; nothing may be replayed.
        extra = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge Clock);
            if (ReadRedbus || WriteRedbus || CpuWait) extra++;
        end
        CpuRead = 1'b0; CpuWrite = 1'b0;
        @(negedge Clock);
        if (ReadRedbus || WriteRedbus || CpuWait) extra++;
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL %s no_replay got %0d active cycles want 0", tag, extra);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        CpuAddress = 16'h0000; CpuWData = 8'h00; CpuRead = 1'b0; CpuWrite = 1'b0;
        RbEnable = 1'b0; RbDevice = 8'h00; DataIn = 8'h00; RbAck = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({CpuRData, CpuWait, RbDeviceSel, Address, DataOut,
             ReadRedbus, WriteRedbus, RbTimeout} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdata %h wait %b dev %h addr %h data %h rd %b wr %b to %b want all 0",
                     CpuRData, CpuWait, RbDeviceSel, Address, DataOut,
                     ReadRedbus, WriteRedbus, RbTimeout);
        end
        Reset = 1'b0;
        exp_rdata = 8'h00;
        exp_to    = 1'b0;
    endtask

    task automatic test_directed();
        xfer("t1_read_ack2",   16'h0381, 8'h00, 1, 0, 1, 8'd2, 2, 8'h5A, 0);
        xfer("t2_write_ack1",  16'h0380, 8'h12, 0, 1, 1, 8'd2, 1, 8'h00, 0);
        xfer("t3_read_noack",  16'h03C0, 8'h00, 1, 0, 1, 8'd4, 0, 8'h33, 0);
        xfer("t3_clear_flag",  16'h0301, 8'h00, 1, 0, 1, 8'd4, 3, 8'hA7, 0);
        xfer("t4_hold_read",   16'h03FF, 8'h00, 1, 0, 1, 8'd7, 1, 8'h3C, 5);
        xfer("ack_at_limit",   16'h0300, 8'h00, 1, 0, 1, 8'd1, TMO, 8'hC3, 0);
        xfer("ack_too_late",   16'h0310, 8'h00, 1, 0, 1, 8'd1, TMO + 1, 8'h11, 0);
        xfer("write_keeps_ff", 16'h0320, 8'h99, 0, 1, 1, 8'd9, 4, 8'h00, 1);
    endtask

    task automatic test_outside();
        xfer("t5_other_page",  16'h0480, 8'h00, 1, 0, 1, 8'd2, 1, 8'h44, 0);
        xfer("t5_disabled",    16'h0380, 8'h55, 0, 1, 0, 8'd2, 1, 8'h00, 0);
        xfer("t5_no_request",  16'h0380, 8'h55, 0, 0, 1, 8'd2, 1, 8'h00, 0);
        xfer("t5_rd_and_wr",   16'h0342, 8'h6E, 1, 1, 1, 8'd5, 2, 8'hEE, 0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        @(posedge Clock); #1;
        CpuAddress = 16'h0390; CpuRead = 1'b1; CpuWrite = 1'b0;
        RbEnable = 1'b1; RbDevice = 8'd6; RbAck = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge Clock);
            if (ReadRedbus) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t6_strobe_start got no strobe want strobe within 10 cycles");
        end
        Reset = 1'b1;
        #1;
        checks++;
        if (ReadRedbus !== 1'b0 || CpuWait !== 1'b0) begin
            errors++;
            $display("FAIL t6_async_drop got rd %b wait %b want 0 0", ReadRedbus, CpuWait);
        end
        @(posedge Clock); #1;
        CpuRead = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        exp_rdata = 8'h00;
        exp_to    = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            if (ReadRedbus || WriteRedbus || CpuWait) seen = 1;
        end
        checks++;
        if (seen || CpuRData !== 8'h00 || RbTimeout !== 1'b0) begin
            errors++;
            $display("FAIL t6_idle_after got active %0d rdata %h to %b want 0 00 0",
                     seen, CpuRData, RbTimeout);
        end
        xfer("t6_after_reset", 16'h0302, 8'h00, 1, 0, 1, 8'd3, 1, 8'h7D, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] addr;
            int          op;
            addr = ($urandom_range(0, 4) != 0) ? {8'h03, 8'($urandom)} : 16'($urandom);
            op   = $urandom_range(0, 3);
            xfer($sformatf("rand%0d", i), addr, 8'($urandom),
                 (op == 0 || op == 2), (op == 1 || op == 2),
                 ($urandom_range(0, 7) != 0), 8'($urandom),
                 $urandom_range(0, TMO + 2), 8'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_outside();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
